sensor_poll_ctrl: RTL

//  AXI-lite master that drives sensor_axi. After enable it writes two config registers, then

---
 rtl/sensor_poll_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sensor_poll_ctrl.sv
// AXI-lite master: writes two sensor config registers once per enable, then periodically
// reads DATA_LEN consecutive data registers into a packed sample with a valid pulse.
module sensor_poll_ctrl #(
   parameter logic [7:0]  CFG_REG0    = 8'hF4,
   parameter logic [7:0]  CFG_VAL0    = 8'h27,
   parameter logic [7:0]  CFG_REG1    = 8'hF5,
   parameter logic [7:0]  CFG_VAL1    = 8'hA0,
   parameter logic [7:0]  DATA_BASE   = 8'hF7,
   parameter int unsigned DATA_LEN    = 8,
   parameter logic [31:0] POLL_PERIOD = 32'd83000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  err_clr,
   output logic [31:0]           axi_araddr,
   output logic                  axi_arvalid,
   input  logic                  axi_arready,
   input  logic [31:0]           axi_rdata,
   input  logic                  axi_rvalid,
   output logic                  axi_rready,
   output logic [31:0]           axi_awaddr,
   output logic                  axi_awvalid,
   input  logic                  axi_awready,
   output logic [31:0]           axi_wdata,
   output logic                  axi_wvalid,
   input  logic                  axi_wready,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [1:0]            b_response,
   output logic [8*DATA_LEN-1:0] sample_data,
   output logic                  sample_valid,
   output logic [15:0]           sample_count,
   output logic                  err_nack,
   output logic                  err_bresp,
   output logic                  busy
);

   typedef enum logic [2:0] {StIdle, StCfgW, StCfgB, StRdAr, StRdR, StDone, StWait} state_t;

   state_t                state_q, state_d;
   logic                  cfg_idx_q, cfg_idx_d;
   logic [3:0]            rd_idx_q, rd_idx_d;
   logic                  aw_done_q, w_done_q;
   logic                  bad_q;
   logic [31:0]           period_q;
   logic [8*DATA_LEN-1:0] shadow_q;
   logic                  start_poll, aw_hs, w_hs, r_hs, last_rd, good_done, nack_seen;
   logic [7:0]            cfg_reg, cfg_val, rd_reg;
   logic                  unused_rdata;

   assign unused_rdata = ^axi_rdata[31:9];

   assign cfg_reg = cfg_idx_q ? CFG_REG1 : CFG_REG0;
   assign cfg_val = cfg_idx_q ? CFG_VAL1 : CFG_VAL0;
   assign rd_reg  = DATA_BASE + {4'd0, rd_idx_q};

   always_comb begin
      busy        = !((state_q == StIdle) || (state_q == StWait));
      axi_arvalid = (state_q == StRdAr);
      axi_rready  = (state_q == StRdR);
      axi_awvalid = (state_q == StCfgW) && !aw_done_q;
      axi_wvalid  = (state_q == StCfgW) && !w_done_q;
      b_ready     = (state_q == StCfgB);
      axi_araddr  = axi_arvalid ? {22'd0, rd_reg, 2'b00} : 32'd0;
      axi_awaddr  = axi_awvalid ? {22'd0, cfg_reg, 2'b00} : 32'd0;
      axi_wdata   = axi_wvalid ? {24'd0, cfg_val} : 32'd0;
   end

   assign aw_hs     = axi_awvalid && axi_awready;
   assign w_hs      = axi_wvalid && axi_wready;
   assign r_hs      = axi_rready && axi_rvalid;
   assign nack_seen = r_hs && axi_rdata[8];
   assign last_rd   = (rd_idx_q == 4'(DATA_LEN - 1));
   // A sample is only published if the poll ran to completion with enable still high.
   assign good_done = (state_q == StDone) && enable && !bad_q;

   always_comb begin
      state_d    = state_q;
      cfg_idx_d  = cfg_idx_q;
      rd_idx_d   = rd_idx_q;
      start_poll = 1'b0;
      case (state_q)
         StIdle: begin
            if (enable) begin
               state_d   = StCfgW;
               cfg_idx_d = 1'b0;
            end
         end
         StCfgW: begin
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StCfgB;
         end
         StCfgB: begin
            if (b_valid) begin
               if (!enable) begin
                  state_d = StIdle;
               end else if (!cfg_idx_q) begin
                  cfg_idx_d = 1'b1;
                  state_d   = StCfgW;
               end else begin
                  state_d    = StRdAr;
                  start_poll = 1'b1;
               end
            end
         end
         StRdAr: begin
            if (axi_arready) state_d = StRdR;
         end
         StRdR: begin
            if (axi_rvalid) begin
               if (!enable) begin
                  state_d = StIdle;
               end else if (last_rd) begin
                  state_d = StDone;
               end else begin
                  rd_idx_d = rd_idx_q + 4'd1;
                  state_d  = StRdAr;
               end
            end
         end
         StDone, StWait: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (period_q == 32'd0) begin
               state_d    = StRdAr;
               start_poll = 1'b1;
            end else begin
               state_d = StWait;
            end
         end
         default: state_d = StIdle;
      endcase
      if (start_poll) rd_idx_d = 4'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cfg_idx_q    <= 1'b0;
         rd_idx_q     <= 4'd0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         bad_q        <= 1'b0;
         period_q     <= 32'd0;
         shadow_q     <= '0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
         sample_count <= 16'd0;
         err_nack     <= 1'b0;
         err_bresp    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_idx_q <= cfg_idx_d;
         rd_idx_q  <= rd_idx_d;
         aw_done_q <= (state_q == StCfgW) && (aw_done_q || aw_hs);
         w_done_q  <= (state_q == StCfgW) && (w_done_q || w_hs);
         if (start_poll) period_q <= POLL_PERIOD - 32'd1;
         else if (period_q != 32'd0) period_q <= period_q - 32'd1;
         if (start_poll) bad_q <= 1'b0;
         else if (nack_seen) bad_q <= 1'b1;
         if (r_hs) shadow_q[{rd_idx_q, 3'b000} +: 8] <= axi_rdata[7:0];
         sample_valid <= good_done;
         if (good_done) begin
            sample_data  <= shadow_q;
            sample_count <= sample_count + 16'd1;
         end
         // A new error in the same cycle as err_clr keeps the flag set.
         err_nack  <= nack_seen || (err_nack && !err_clr);
         err_bresp <= ((state_q == StCfgB) && b_valid && (b_response != 2'b00)) ||
                      (err_bresp && !err_clr);
      end
   end

endmodule
